// File: rtl/mc8051_mem_resp.sv
`default_nettype none
// ============================================================================
// mc8051_mem_resp : one-at-a-time memory responder (IRAM / SFR bus / XDATA bus)
// Rev 1.0
// ============================================================================
module mc8051_mem_resp #(
  parameter int unsigned TMO_CYC = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic        i_req_space,
  input  logic        i_req_indirect,
  input  logic [15:0] i_req_addr,
  input  logic [7:0]  i_req_wdata,
  output logic        o_rsp_valid,
  output logic [7:0]  o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_sfr_req,
  output logic        o_sfr_we,
  output logic [7:0]  o_sfr_addr,
  output logic [7:0]  o_sfr_wdata,
  input  logic        i_sfr_ack,
  input  logic [7:0]  i_sfr_rdata,
  output logic        o_ext_req,
  output logic        o_ext_we,
  output logic [15:0] o_ext_addr,
  output logic [7:0]  o_ext_wdata,
  input  logic        i_ext_ack,
  input  logic [7:0]  i_ext_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SFR_WAIT = 2'd1,
    EXT_WAIT = 2'd2,
    RESP     = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] tmo_cnt;
  logic [7:0] iram [256];
  logic       accept;
  logic       sel_ext;
  logic       sel_iram;
  logic       bus_ack;
  logic       bus_we;
  logic [7:0] bus_rdata;
  logic       tmo_hit;

  assign accept   = i_req_valid && (state == IDLE);
  assign sel_ext  = i_req_space;
  // Indirect accesses to the upper half reach IRAM, never the SFRs.
  assign sel_iram = !i_req_space && (!i_req_addr[7] || i_req_indirect);

  // Only the bus owned by the current wait state may complete it.
  always_comb begin
    bus_ack   = 1'b0;
    bus_we    = 1'b0;
    bus_rdata = 8'h00;
    case (state)
      SFR_WAIT: begin
        bus_ack   = i_sfr_ack;
        bus_we    = o_sfr_we;
        bus_rdata = i_sfr_rdata;
      end
      EXT_WAIT: begin
        bus_ack   = i_ext_ack;
        bus_we    = o_ext_we;
        bus_rdata = i_ext_rdata;
      end
      default: ;
    endcase
  end

  // An ack in the final allowed cycle wins over the timeout.
  assign tmo_hit     = !bus_ack && (tmo_cnt == TMO_LAST);
  assign o_req_ready = (state == IDLE);
  assign o_rsp_valid = (state == RESP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (sel_ext)       state_nxt = EXT_WAIT;
          else if (sel_iram) state_nxt = RESP;
          else               state_nxt = SFR_WAIT;
        end
      end
      SFR_WAIT, EXT_WAIT: begin
        if (bus_ack || tmo_hit) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (accept && sel_iram && i_req_we) iram[i_req_addr[7:0]] <= i_req_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt     <= 8'h00;
      o_rsp_rdata <= 8'h00;
      o_rsp_err   <= 1'b0;
      o_sfr_req   <= 1'b0;
      o_sfr_we    <= 1'b0;
      o_sfr_addr  <= 8'h00;
      o_sfr_wdata <= 8'h00;
      o_ext_req   <= 1'b0;
      o_ext_we    <= 1'b0;
      o_ext_addr  <= 16'h0000;
      o_ext_wdata <= 8'h00;
    end else if (accept) begin
      tmo_cnt     <= 8'h00;
      o_rsp_err   <= 1'b0;
      o_rsp_rdata <= 8'h00;
      if (sel_ext) begin
        o_ext_req   <= 1'b1;
        o_ext_we    <= i_req_we;
        o_ext_addr  <= i_req_addr;
        o_ext_wdata <= i_req_wdata;
      end else if (sel_iram) begin
        if (!i_req_we) o_rsp_rdata <= iram[i_req_addr[7:0]];
      end else begin
        o_sfr_req   <= 1'b1;
        o_sfr_we    <= i_req_we;
        o_sfr_addr  <= i_req_addr[7:0];
        o_sfr_wdata <= i_req_wdata;
      end
    end else if (state == SFR_WAIT || state == EXT_WAIT) begin
      if (bus_ack || tmo_hit) begin
        o_sfr_req <= 1'b0;
        o_ext_req <= 1'b0;
      end
      if (bus_ack) begin
        if (!bus_we) o_rsp_rdata <= bus_rdata;
      end else if (tmo_hit) begin
        o_rsp_err   <= 1'b1;
        o_rsp_rdata <= 8'hFF;
      end else begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire
